// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S receiver.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StWait
  } state_e;

  localparam logic ChLeft  = 1'b0;
  localparam logic ChRight = 1'b1;

  // Legal range of captured bits per slot.
  localparam int unsigned DataWMin = 8;
  localparam int unsigned DataWMax = 32;

  function automatic bit data_w_ok(int unsigned w);
    return (w >= DataWMin) && (w <= DataWMax);
  endfunction

  // Bit indices of the synchronized input bundle.
  localparam int unsigned IdxBclk  = 0;
  localparam int unsigned IdxLrclk = 1;
  localparam int unsigned IdxSdata = 2;

endpackage

// File: rtl/i2s_rx_sync.sv
// Two-flop synchronizer for BCLK/LRCLK/SDATA plus a BCLK rising-edge pulse.
module i2s_rx_sync
  import i2s_rx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] async_i,
  output logic [2:0] sync_o,
  output logic       bclk_rise_o
);

  logic [2:0] meta_q, sync_q;
  logic       bclk_prev_q;

  // Synchronizer chain and previous synced BCLK for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q      <= '0;
      sync_q      <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      meta_q      <= async_i;
      sync_q      <= meta_q;
      bclk_prev_q <= sync_q[IdxBclk];
    end
  end

  assign sync_o      = sync_q;
  assign bclk_rise_o = sync_q[IdxBclk] & ~bclk_prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S capture: deserializes left/right slots and presents stereo pairs on valid/ready.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              frame_err,
  input  logic              status_clr
);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("i2s_rx: DATA_W out of range");
  end

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [2:0] sync;
  logic       bclk_rise;
  logic       lr_s, sd_s;

  i2s_rx_sync u_sync (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .async_i     ({i2s_sdata, i2s_lrclk, i2s_bclk}),
    .sync_o      (sync),
    .bclk_rise_o (bclk_rise)
  );

  assign lr_s = sync[IdxLrclk];
  assign sd_s = sync[IdxSdata];

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] out_left_q, out_left_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  logic              channel_q, channel_d;
  logic              lr_prev_q, lr_prev_d;
  logic              left_ok_q, left_ok_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;

  logic slot_start, commit, accept, short_slot;

  assign slot_start = bclk_rise & (lr_s != lr_prev_q);
  assign accept     = out_valid_q & out_ready;

  // Capture FSM, pairing, output register and sticky flags.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    hold_l_d    = hold_l_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    channel_d   = channel_q;
    lr_prev_d   = lr_prev_q;
    left_ok_d   = left_ok_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    commit      = 1'b0;
    short_slot  = 1'b0;

    if (bclk_rise) lr_prev_d = lr_s;

    if (!enable) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      left_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (slot_start) begin
            state_d   = StShift;
            bit_cnt_d = '0;
            channel_d = lr_s;
          end
        end
        StShift: begin
          if (bit_cnt_q == CntW'(DATA_W)) begin
            state_d = StWait;
            if (channel_q == ChLeft) begin
              hold_l_d  = shreg_q;
              left_ok_d = 1'b1;
            end else begin
              commit    = left_ok_q;
              left_ok_d = 1'b0;
            end
          end else if (slot_start) begin
            // Slot ended early: drop the word and any pending left half.
            short_slot = 1'b1;
            left_ok_d  = 1'b0;
            bit_cnt_d  = '0;
            channel_d  = lr_s;
          end else if (bclk_rise) begin
            shreg_d   = {shreg_q[DATA_W-2:0], sd_s};
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StWait: begin
          if (slot_start) begin
            state_d   = StShift;
            bit_cnt_d = '0;
            channel_d = lr_s;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (status_clr) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (short_slot) frame_err_d = 1'b1;

    if (commit && (!out_valid_q || accept)) begin
      out_left_d  = hold_l_q;
      out_right_d = shreg_q;
      out_valid_d = 1'b1;
    end else if (commit) begin
      overflow_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      hold_l_q    <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      channel_q   <= ChLeft;
      lr_prev_q   <= 1'b0;
      left_ok_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      hold_l_q    <= hold_l_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      channel_q   <= channel_d;
      lr_prev_q   <= lr_prev_d;
      left_ok_q   <= left_ok_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: 24-bit words in 32-BCLK slots, BCLK = clk/8.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [23:0] out_left, out_right;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow, frame_err;
  logic        status_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int last_rise_cyc = 0;
  int valid_cnt = 0;
  int valid_rise_cyc = 0;
  int base;
  logic v_prev = 1'b0;
  logic [23:0] snap_l, snap_r;
  logic        snap_v, snap_o, snap_f;

  i2s_rx #(.DATA_W(24)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .enable        (enable),
    .i2s_bclk      (bclk),
    .i2s_lrclk     (lrclk),
    .i2s_sdata     (sdata),
    .out_left      (out_left),
    .out_right     (out_right),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .frame_err     (frame_err),
    .status_clr    (status_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts cycles with out_valid high and records when it last rose.
  always @(negedge clk) begin
    if (out_valid) valid_cnt <= valid_cnt + 1;
    if (out_valid && !v_prev) valid_rise_cyc <= cyc;
    v_prev <= out_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One BCLK period (8 clk), data set while BCLK low, rise mid-period.
  task automatic send_bit(input logic lr, input logic d, input bit do_rst, input bit rdy_pulse);
    bclk = 1'b0;
    lrclk = lr;
    sdata = d;
    if (do_rst) begin
      rst_n = 1'b0;
      @(negedge clk);
      snap_l = out_left;
      snap_r = out_right;
      snap_v = out_valid;
      snap_o = overflow;
      snap_f = frame_err;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    bclk = 1'b1;
    rise_cyc = cyc;
    if (rdy_pulse) begin
      // Ready high only for the clk edge where the pair commits.
      repeat (3) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // Slot: bit 0 is the previous word's trailing bit, bits 1..24 the word MSB first.
  task automatic send_slot(input logic lr, input logic [23:0] w, input int nbits,
                           input int rst_at, input int en_off_at, input bit rdy_pulse);
    for (int i = 0; i < nbits; i++) begin
      logic d;
      d = (i >= 1 && i <= 24) ? w[24-i] : 1'b0;
      if (i == en_off_at) enable = 1'b0;
      if (i == en_off_at + 3) enable = 1'b1;
      send_bit(lr, d, (i == rst_at), (rdy_pulse && i == 24));
      if (i == 24) last_rise_cyc = rise_cyc;
    end
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, l, 32, -1, -100, 1'b0);
    send_slot(1'b1, r, 32, -1, -100, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_left", 32'(out_left), 32'h0);
    chk("rst_right", 32'(out_right), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Prime: a right slot gives the first slot start; its word has no left partner.
    out_ready = 1'b1;
    base = valid_cnt;
    send_slot(1'b1, 24'h777777, 32, -1, -100, 1'b0);
    chk("prime_no_commit", 32'(valid_cnt - base), 32'd0);

    // Basic pair with consumer always ready.
    base = valid_cnt;
    frame(24'hA5A5A5, 24'h5A5A5A);
    chk("t1_left", 32'(out_left), 32'hA5A5A5);
    chk("t1_right", 32'(out_right), 32'h5A5A5A);
    chk("t1_valid_width", 32'(valid_cnt - base), 32'd1);
    chk("t1_latency", 32'(valid_rise_cyc - last_rise_cyc), 32'd4);
    chk("t1_valid_low", 32'(out_valid), 32'h0);

    // Backpressure: second pair dropped, overflow set.
    out_ready = 1'b0;
    frame(24'h000001, 24'h000002);
    frame(24'h000003, 24'h000004);
    chk("t2_left", 32'(out_left), 32'h000001);
    chk("t2_right", 32'(out_right), 32'h000002);
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_overflow", 32'(overflow), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_accept_valid", 32'(out_valid), 32'h0);
    chk("t2_accept_left", 32'(out_left), 32'h000001);
    chk("t2_overflow_sticky", 32'(overflow), 32'h1);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    chk("t2_clr_overflow", 32'(overflow), 32'h0);

    // Accept coinciding with a new commit.
    out_ready = 1'b0;
    frame(24'h111111, 24'h222222);
    chk("t6_pre_valid", 32'(out_valid), 32'h1);
    send_slot(1'b0, 24'h333333, 32, -1, -100, 1'b0);
    send_slot(1'b1, 24'h444444, 32, -1, -100, 1'b1);
    chk("t6_left", 32'(out_left), 32'h333333);
    chk("t6_right", 32'(out_right), 32'h444444);
    chk("t6_valid", 32'(out_valid), 32'h1);
    chk("t6_overflow", 32'(overflow), 32'h0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_drain", 32'(out_valid), 32'h0);

    // Raw words, no sign extension.
    base = valid_cnt;
    frame(24'hFFFFFF, 24'h800000);
    chk("t5_left", 32'(out_left), 32'h00FFFFFF);
    chk("t5_right", 32'(out_right), 32'h00800000);
    chk("t5_commits", 32'(valid_cnt - base), 32'd1);

    // Enable dropped mid-left-slot: that frame must not commit.
    base = valid_cnt;
    send_slot(1'b0, 24'h121212, 32, -1, 12, 1'b0);
    send_slot(1'b1, 24'h343434, 32, -1, -100, 1'b0);
    chk("t5_en_no_commit", 32'(valid_cnt - base), 32'd0);
    chk("t5_en_right_kept", 32'(out_right), 32'h800000);
    frame(24'h246813, 24'h135792);
    chk("t5_en_left", 32'(out_left), 32'h246813);
    chk("t5_en_right", 32'(out_right), 32'h135792);
    chk("t5_en_commits", 32'(valid_cnt - base), 32'd1);

    // Short left slot: frame error, no commit.
    base = valid_cnt;
    send_slot(1'b0, 24'hABCDEF, 16, -1, -100, 1'b0);
    send_slot(1'b1, 24'h999999, 32, -1, -100, 1'b0);
    chk("t3_frame_err", 32'(frame_err), 32'h1);
    chk("t3_no_commit", 32'(valid_cnt - base), 32'd0);
    chk("t3_left_kept", 32'(out_left), 32'h246813);
    out_ready = 1'b0;
    frame(24'h123456, 24'h654321);
    chk("t3_left", 32'(out_left), 32'h123456);
    chk("t3_right", 32'(out_right), 32'h654321);
    chk("t3_valid", 32'(out_valid), 32'h1);
    chk("t3_frame_err_sticky", 32'(frame_err), 32'h1);

    // Reset at left bit 10.
    send_slot(1'b0, 24'hAAAAAA, 32, 10, -100, 1'b0);
    chk("t4_rst_left", 32'(snap_l), 32'h0);
    chk("t4_rst_right", 32'(snap_r), 32'h0);
    chk("t4_rst_valid", 32'(snap_v), 32'h0);
    chk("t4_rst_overflow", 32'(snap_o), 32'h0);
    chk("t4_rst_frame_err", 32'(snap_f), 32'h0);
    out_ready = 1'b1;
    base = valid_cnt;
    send_slot(1'b1, 24'hABCDEF, 32, -1, -100, 1'b0);
    chk("t4_mid_right_dropped", 32'(valid_cnt - base), 32'd0);
    chk("t4_mid_right_out", 32'(out_right), 32'h0);
    frame(24'h0F0F0F, 24'hF0F0F0);
    chk("t4_left", 32'(out_left), 32'h0F0F0F);
    chk("t4_right", 32'(out_right), 32'hF0F0F0);
    chk("t4_commits", 32'(valid_cnt - base), 32'd1);
    chk("t4_frame_err", 32'(frame_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
